axi2mem_tcdm_wr_if: RTL and testbench
=====================================

// Module: axi2mem_tcdm_wr_if
// PURPOSE
//  Downstream of the AXI write-channel front end: buffers its dual-lane write commands
//  (two 32-bit lanes per 64-bit beat) and write data, then drives two 32-bit TCDM master ports.
//  Emits one write-completion request (trans_r_req_o/trans_r_id_o) per AXI burst once both
//  lanes have had the burst's last beat acknowledged by TCDM.
// PARAMETERS
//  CMD_DEPTH   4  entries per lane in the command FIFO and in the data FIFO (power of 2, >=2)
//  RESP_DEPTH  4  entries per lane in the completion-ID FIFO (power of 2, >=2)
//  ID_WIDTH    6  width of trans_id / trans_r_id
// PORTS
//  clk_i             in   1      clock
//  rst_ni            in   1      asynchronous active-low reset
//  trans_id_i        in   2x6    per-lane burst ID
//  trans_add_i       in   2x32   per-lane byte address (lane1 = lane0 + 4)
//  trans_last_i      in   2      per-lane last beat of burst
//  trans_req_i       in   2      per-lane command valid
//  trans_gnt_o       out  2      per-lane command FIFO not full
//  data_dat_i        in   64     beat data; [31:0] lane0, [63:32] lane1
//  data_strb_i       in   8      byte strobes; [3:0] lane0, [7:4] lane1
//  data_req_i        in   1      data valid
//  data_gnt_o        out  1      both lane data FIFOs not full
//  trans_r_req_o     out  1      burst write completion valid
//  trans_r_id_o      out  6      ID of completed burst
//  trans_r_gnt_i     in   1      completion accepted
//  tcdm_req_o        out  2      TCDM request per lane
//  tcdm_add_o        out  2x32   TCDM address
//  tcdm_wen_o        out  2      write enable, active low; always 0 when req
//  tcdm_be_o         out  2x4    byte enables
//  tcdm_wdata_o      out  2x32   write data
//  tcdm_gnt_i        in   2      TCDM grant
//  tcdm_r_valid_i    in   2      TCDM response, exactly 1 cycle after grant
// BEHAVIOUR
//  - Reset: all FIFOs empty, in-flight flags clear; every output 0 while rst_ni=0;
//    trans_gnt_o=2'b11, data_gnt_o=1 from first cycle after release. Reset mid-burst drops all
//    buffered beats and pending completions; no TCDM req or completion is issued for them.
//  - trans_gnt_o/data_gnt_o are ready-style, depend only on FIFO occupancy (never on req);
//    upstream may raise req only while gnt is high. Push cmd lane i on trans_req_i[i]&trans_gnt_o[i];
//    push both data lanes on data_req_i&data_gnt_o. Push while full is impossible by construction.
//  - Simultaneous push and pop on a full FIFO: gnt still 0 that cycle (no bypass).
//  - Lanes are independent. Lane i asserts tcdm_req_o[i] when cmd FIFO and data FIFO of lane i
//    are both non-empty and the last-beat stall is clear; add/be/wdata come from FIFO heads,
//    wen=0. Fields held stable while req=1 and gnt=0. Pop both lane-i heads on req&gnt.
//  - Throughput: one beat per lane per cycle with gnt held high. Latency: cmd+data pushed in
//    cycle N -> tcdm_req_o earliest in cycle N+1 (registered FIFO outputs).
//  - Last-beat stall: lane i does not issue a head with last=1 if its completion FIFO is full or
//    a last beat is already in flight (granted, r_valid pending).
//  - On gnt of a last beat, lane i latches its ID and sets in-flight flag; on the following
//    tcdm_r_valid_i[i] it pushes the ID into completion FIFO i and clears the flag.
//  - trans_r_req_o = both completion FIFOs non-empty; trans_r_id_o = lane0 head. Pop both on
//    trans_r_req_o&trans_r_gnt_i; held stable otherwise. Lane0/lane1 head IDs mismatch is
//    an upstream protocol error; lane0 ID wins (assertion in simulation).
//  - FIFO pointers wrap modulo depth; occupancy counters are log2(depth)+1 bits.
// TESTING
//  - Single beat id=5, add0=0x100, add1=0x104, data=0xAABBCCDD_11223344, strb=0xFF, gnt=11 ->
//    cycle+1 TCDM writes 0x11223344@0x100, 0xAABBCCDD@0x104 be=F; 2 cycles later r_req id=5.
//  - 4-beat burst id=2 at 0x200, tcdm_gnt_i=11 -> 4 back-to-back beats per lane, addresses
//    0x200..0x218 step 8; exactly one completion id=2 after last r_valid.
//  - tcdm_gnt_i[1]=0 for 10 cycles during 8-beat burst -> lane1 fills, trans_gnt_o[1]=0 after
//    CMD_DEPTH beats, data_gnt_o=0; no data lost, ordering kept; completion after lane1 drains.
//  - 5 single-beat bursts ids 1..5 with trans_r_gnt_i=0 -> 4 completions queued, 5th last beat
//    stalled at TCDM; release r_gnt -> ids 1,2,3,4,5 returned in order.
//  - strb=0x0F on beat -> lane0 be=F, lane1 be=0 (request still issued, completion counted).
//  - Assert rst_ni=0 with 3 beats buffered -> all outputs 0; after release no TCDM req, no r_req.

Source files
------------

// File: rtl/axi2mem_tcdm_wr_if_if.sv
// Bus bundle between the AXI write front end, the TCDM write interface and the two TCDM ports.
// The slave modport is the write-interface view; the master modport is the surrounding system.
interface axi2mem_tcdm_wr_if_if #(
  parameter int unsigned ID_WIDTH = 6
);
  logic [1:0][ID_WIDTH-1:0] trans_id_i;
  logic [1:0][31:0]         trans_add_i;
  logic [1:0]               trans_last_i;
  logic [1:0]               trans_req_i;
  logic [1:0]               trans_gnt_o;
  logic [63:0]              data_dat_i;
  logic [7:0]               data_strb_i;
  logic                     data_req_i;
  logic                     data_gnt_o;
  logic                     trans_r_req_o;
  logic [ID_WIDTH-1:0]      trans_r_id_o;
  logic                     trans_r_gnt_i;
  logic [1:0]               tcdm_req_o;
  logic [1:0][31:0]         tcdm_add_o;
  logic [1:0]               tcdm_wen_o;
  logic [1:0][3:0]          tcdm_be_o;
  logic [1:0][31:0]         tcdm_wdata_o;
  logic [1:0]               tcdm_gnt_i;
  logic [1:0]               tcdm_r_valid_i;

  modport slave (
    input  trans_id_i, trans_add_i, trans_last_i, trans_req_i,
    output trans_gnt_o,
    input  data_dat_i, data_strb_i, data_req_i,
    output data_gnt_o,
    output trans_r_req_o, trans_r_id_o,
    input  trans_r_gnt_i,
    output tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_be_o, tcdm_wdata_o,
    input  tcdm_gnt_i, tcdm_r_valid_i
  );

  modport master (
    output trans_id_i, trans_add_i, trans_last_i, trans_req_i,
    input  trans_gnt_o,
    output data_dat_i, data_strb_i, data_req_i,
    input  data_gnt_o,
    input  trans_r_req_o, trans_r_id_o,
    output trans_r_gnt_i,
    input  tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_be_o, tcdm_wdata_o,
    output tcdm_gnt_i, tcdm_r_valid_i
  );
endinterface

// File: rtl/axi2mem_tcdm_wr_if.sv
// TCDM write interface: per-lane command/data FIFOs feeding two 32-bit TCDM ports and
// a per-lane completion-ID FIFO pair that yields one write completion per AXI burst.

module axi2mem_tcdm_wr_if_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wptr_r;
  logic [PW-1:0]    rptr_r;
  logic [CW-1:0]    cnt_r;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cnt_r  <= '0;
    end else begin
      if (push) wptr_r <= wptr_r + 1'b1;
      if (pop)  rptr_r <= rptr_r + 1'b1;
      case ({push, pop})
        2'b10:   cnt_r <= cnt_r + 1'b1;
        2'b01:   cnt_r <= cnt_r - 1'b1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Storage needs no reset: contents are only visible through a non-zero count.
  always_ff @(posedge clk_i) begin
    if (push) mem_r[wptr_r] <= wdata;
  end

  assign rdata = mem_r[rptr_r];
  assign empty = (cnt_r == '0);
  assign full  = (cnt_r == CW'(DEPTH));
endmodule

module axi2mem_tcdm_wr_if_chk #(
  parameter int unsigned ID_WIDTH = 6
) (
  input logic                clk_i,
  input logic                rst_ni,
  input logic                r_req,
  input logic [ID_WIDTH-1:0] id0,
  input logic [ID_WIDTH-1:0] id1
);
  a_lane_id_match: assert property (@(posedge clk_i) disable iff (!rst_ni) r_req |-> (id0 == id1));
endmodule

module axi2mem_tcdm_wr_if #(
  parameter int unsigned CMD_DEPTH  = 4,
  parameter int unsigned RESP_DEPTH = 4,
  parameter int unsigned ID_WIDTH   = 6
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  axi2mem_tcdm_wr_if_if.slave  bus
);
  localparam int unsigned CMD_W = ID_WIDTH + 33;
  localparam int unsigned DAT_W = 36;

  logic                rdy_r;
  logic [1:0]          trans_gnt_s;
  logic                data_gnt_s;
  logic [1:0]          cmd_push_s, cmd_pop_s, cmd_empty_s, cmd_full_s;
  logic [1:0]          dat_push_s, dat_empty_s, dat_full_s;
  logic [1:0]          rsp_push_s, rsp_pop_s, rsp_empty_s, rsp_full_s;
  logic [1:0]          issue_s;
  logic                rsp_req_s;
  logic [CMD_W-1:0]    cmd_head_s [2];
  logic [DAT_W-1:0]    dat_head_s [2];
  logic [ID_WIDTH-1:0] rsp_head_s [2];

  // Grants open one cycle after reset release so every output is 0 while in reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdy_r <= 1'b0;
    else         rdy_r <= 1'b1;
  end

  assign trans_gnt_s     = {2{rdy_r}} & ~cmd_full_s;
  assign data_gnt_s      = rdy_r & ~dat_full_s[0] & ~dat_full_s[1];
  assign bus.trans_gnt_o = trans_gnt_s;
  assign bus.data_gnt_o  = data_gnt_s;

  for (genvar l = 0; l < 2; l++) begin : g_lane
    logic                inflight_r;
    logic [ID_WIDTH-1:0] last_id_r;
    logic                head_last_s;

    assign head_last_s   = cmd_head_s[l][0];
    assign cmd_push_s[l] = bus.trans_req_i[l] & trans_gnt_s[l];
    assign dat_push_s[l] = bus.data_req_i & data_gnt_s;

    axi2mem_tcdm_wr_if_fifo #(.DEPTH(CMD_DEPTH), .WIDTH(CMD_W)) i_cmd_fifo (
      .clk_i (clk_i), .rst_ni (rst_ni),
      .push  (cmd_push_s[l]),
      .wdata ({bus.trans_id_i[l], bus.trans_add_i[l], bus.trans_last_i[l]}),
      .pop   (cmd_pop_s[l]),
      .rdata (cmd_head_s[l]),
      .empty (cmd_empty_s[l]),
      .full  (cmd_full_s[l])
    );

    axi2mem_tcdm_wr_if_fifo #(.DEPTH(CMD_DEPTH), .WIDTH(DAT_W)) i_dat_fifo (
      .clk_i (clk_i), .rst_ni (rst_ni),
      .push  (dat_push_s[l]),
      .wdata ({bus.data_strb_i[4*l +: 4], bus.data_dat_i[32*l +: 32]}),
      .pop   (cmd_pop_s[l]),
      .rdata (dat_head_s[l]),
      .empty (dat_empty_s[l]),
      .full  (dat_full_s[l])
    );

    // A last beat waits for room in the completion FIFO and for the previous one to retire.
    assign issue_s[l]    = ~cmd_empty_s[l] & ~dat_empty_s[l] &
                           ~(head_last_s & (rsp_full_s[l] | inflight_r));
    assign cmd_pop_s[l]  = issue_s[l] & bus.tcdm_gnt_i[l];
    assign rsp_push_s[l] = inflight_r & bus.tcdm_r_valid_i[l];

    // Track the granted last beat until its write response returns.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        inflight_r <= 1'b0;
        last_id_r  <= '0;
      end else if (cmd_pop_s[l] & head_last_s) begin
        inflight_r <= 1'b1;
        last_id_r  <= cmd_head_s[l][CMD_W-1:33];
      end else if (rsp_push_s[l]) begin
        inflight_r <= 1'b0;
        last_id_r  <= last_id_r;
      end else begin
        inflight_r <= inflight_r;
        last_id_r  <= last_id_r;
      end
    end

    axi2mem_tcdm_wr_if_fifo #(.DEPTH(RESP_DEPTH), .WIDTH(ID_WIDTH)) i_rsp_fifo (
      .clk_i (clk_i), .rst_ni (rst_ni),
      .push  (rsp_push_s[l]),
      .wdata (last_id_r),
      .pop   (rsp_pop_s[l]),
      .rdata (rsp_head_s[l]),
      .empty (rsp_empty_s[l]),
      .full  (rsp_full_s[l])
    );

    assign bus.tcdm_req_o[l]   = issue_s[l];
    assign bus.tcdm_wen_o[l]   = 1'b0;
    assign bus.tcdm_add_o[l]   = issue_s[l] ? cmd_head_s[l][32:1]  : 32'h0000_0000;
    assign bus.tcdm_be_o[l]    = issue_s[l] ? dat_head_s[l][35:32] : 4'h0;
    assign bus.tcdm_wdata_o[l] = issue_s[l] ? dat_head_s[l][31:0]  : 32'h0000_0000;
  end

  // A burst completes only once both lanes have retired its last beat.
  assign rsp_req_s         = ~rsp_empty_s[0] & ~rsp_empty_s[1];
  assign rsp_pop_s         = {2{rsp_req_s & bus.trans_r_gnt_i}};
  assign bus.trans_r_req_o = rsp_req_s;
  assign bus.trans_r_id_o  = rsp_req_s ? rsp_head_s[0] : '0;

  axi2mem_tcdm_wr_if_chk #(.ID_WIDTH(ID_WIDTH)) i_chk (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .r_req  (rsp_req_s),
    .id0    (rsp_head_s[0]),
    .id1    (rsp_head_s[1])
  );
endmodule

// File: tb/tb_axi2mem_tcdm_wr_if.sv
// Directed bench for axi2mem_tcdm_wr_if: scoreboard queues filled when beats are sent,
// drained by a monitor on TCDM handshakes and write completions.
module tb_axi2mem_tcdm_wr_if;
  typedef struct packed {
    logic [31:0] add;
    logic [3:0]  be;
    logic [31:0] wdata;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi2mem_tcdm_wr_if_if #(.ID_WIDTH(6)) bus ();

  axi2mem_tcdm_wr_if #(.CMD_DEPTH(4), .RESP_DEPTH(4), .ID_WIDTH(6)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int    n_assert = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    hs_cnt   [2];
  int    hs_first [2];
  int    hs_last  [2];
  beat_t exp_q0 [$];
  beat_t exp_q1 [$];
  logic [5:0] id_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // TCDM memory model: write response exactly one cycle after grant
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.tcdm_r_valid_i <= 2'b00;
    else        bus.tcdm_r_valid_i <= bus.tcdm_req_o & bus.tcdm_gnt_i;
  end

  task automatic mon_lane(input int l);
    beat_t e;
    logic  have;
    have = 1'b0;
    if (hs_cnt[l] == 0) hs_first[l] = cyc;
    hs_last[l] = cyc;
    hs_cnt[l]++;
    check($sformatf("tcdm%0d_wen", l), 64'(bus.tcdm_wen_o[l]), 64'h0);
    if (l == 0) begin
      check("tcdm0_expected", 64'(exp_q0.size() != 0), 64'h1);
      if (exp_q0.size() != 0) begin e = exp_q0.pop_front(); have = 1'b1; end
    end else begin
      check("tcdm1_expected", 64'(exp_q1.size() != 0), 64'h1);
      if (exp_q1.size() != 0) begin e = exp_q1.pop_front(); have = 1'b1; end
    end
    if (have) begin
      check($sformatf("tcdm%0d_add", l),   64'(bus.tcdm_add_o[l]),   64'(e.add));
      check($sformatf("tcdm%0d_be", l),    64'(bus.tcdm_be_o[l]),    64'(e.be));
      check($sformatf("tcdm%0d_wdata", l), 64'(bus.tcdm_wdata_o[l]), 64'(e.wdata));
    end
  endtask

  // Monitor samples handshakes on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      for (int l = 0; l < 2; l++)
        if (bus.tcdm_req_o[l] && bus.tcdm_gnt_i[l]) mon_lane(l);
      if (bus.trans_r_req_o && bus.trans_r_gnt_i) begin
        check("resp_expected", 64'(id_q.size() != 0), 64'h1);
        if (id_q.size() != 0) check("resp_id", 64'(bus.trans_r_id_o), 64'(id_q.pop_front()));
      end
    end
  end

  task automatic send_beat(input logic [5:0] id, input logic [31:0] add, input logic last,
                           input logic [63:0] dat, input logic [7:0] strb);
    int waited = 0;
    while (!(bus.trans_gnt_o == 2'b11 && bus.data_gnt_o) && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    check("send_gnt_wait", 64'(waited < 200), 64'h1);
    bus.trans_id_i   = {id, id};
    bus.trans_add_i  = {add + 32'd4, add};
    bus.trans_last_i = {last, last};
    bus.trans_req_i  = 2'b11;
    bus.data_dat_i   = dat;
    bus.data_strb_i  = strb;
    bus.data_req_i   = 1'b1;
    exp_q0.push_back('{add, strb[3:0], dat[31:0]});
    exp_q1.push_back('{add + 32'd4, strb[7:4], dat[63:32]});
    if (last) id_q.push_back(id);
    @(posedge clk); #1;
    bus.trans_req_i = 2'b00;
    bus.data_req_i  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int waited = 0;
    while ((exp_q0.size() + exp_q1.size() + id_q.size()) != 0 && waited < 300) begin
      @(posedge clk); #1;
      waited++;
    end
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_drained"}, 64'(exp_q0.size() + exp_q1.size() + id_q.size()), 64'h0);
  endtask

  task automatic clear_hs();
    for (int l = 0; l < 2; l++) begin
      hs_cnt[l] = 0; hs_first[l] = 0; hs_last[l] = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.trans_id_i    = '0;
    bus.trans_add_i   = '0;
    bus.trans_last_i  = 2'b00;
    bus.trans_req_i   = 2'b00;
    bus.data_dat_i    = 64'h0;
    bus.data_strb_i   = 8'h00;
    bus.data_req_i    = 1'b0;
    bus.trans_r_gnt_i = 1'b1;
    bus.tcdm_gnt_i    = 2'b11;
    clear_hs();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tcdm_req", 64'(bus.tcdm_req_o), 64'h0);
    check("rst_trans_gnt", 64'(bus.trans_gnt_o), 64'h0);
    check("rst_data_gnt", 64'(bus.data_gnt_o), 64'h0);
    check("rst_r_req", 64'(bus.trans_r_req_o), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_trans_gnt", 64'(bus.trans_gnt_o), 64'h3);
    check("post_rst_data_gnt", 64'(bus.data_gnt_o), 64'h1);

    // Single beat, latency to TCDM and to completion
    send_beat(6'd5, 32'h100, 1'b1, 64'hAABBCCDD_11223344, 8'hFF);
    @(negedge clk);
    check("single_req_latency", 64'(bus.tcdm_req_o), 64'h3);
    @(posedge clk); #1;
    @(negedge clk);
    check("single_no_early_resp", 64'(bus.trans_r_req_o), 64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("single_resp_req", 64'(bus.trans_r_req_o), 64'h1);
    check("single_resp_id", 64'(bus.trans_r_id_o), 64'h5);
    drain("single");

    // 4-beat burst, back-to-back per lane
    clear_hs();
    for (int k = 0; k < 4; k++)
      send_beat(6'd2, 32'h200 + 32'(8 * k), (k == 3), {32'hB200_0000 + 32'(k), 32'hA200_0000 + 32'(k)}, 8'hFF);
    drain("burst4");
    check("burst4_hs0", 64'(hs_cnt[0]), 64'd4);
    check("burst4_hs1", 64'(hs_cnt[1]), 64'd4);
    check("burst4_b2b0", 64'(hs_last[0] - hs_first[0]), 64'd3);
    check("burst4_b2b1", 64'(hs_last[1] - hs_first[1]), 64'd3);

    // Lane 1 stalled by TCDM for 10 cycles during an 8-beat burst
    bus.tcdm_gnt_i = 2'b01;
    fork
      begin
        for (int k = 0; k < 8; k++)
          send_beat(6'd7, 32'h300 + 32'(8 * k), (k == 7), {32'hD300_0000 + 32'(k), 32'hC300_0000 + 32'(k)}, 8'hFF);
      end
      begin
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("stall_trans_gnt", 64'(bus.trans_gnt_o), 64'h1);
        check("stall_data_gnt", 64'(bus.data_gnt_o), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        bus.tcdm_gnt_i = 2'b11;
      end
    join
    drain("stall");

    // Completion backpressure: 4 queued, 5th last beat held at TCDM
    bus.trans_r_gnt_i = 1'b0;
    for (int k = 1; k <= 5; k++)
      send_beat(6'(k), 32'h400 + 32'(16 * k), 1'b1, {32'hF400_0000 + 32'(k), 32'hE400_0000 + 32'(k)}, 8'hFF);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("rfull_tcdm_stalled", 64'(bus.tcdm_req_o), 64'h0);
    check("rfull_r_req", 64'(bus.trans_r_req_o), 64'h1);
    check("rfull_head_id", 64'(bus.trans_r_id_o), 64'h1);
    check("rfull_beats_left", 64'(exp_q0.size() + exp_q1.size()), 64'h2);
    @(posedge clk); #1;
    bus.trans_r_gnt_i = 1'b1;
    drain("rfull");

    // Partial strobes still issue on both lanes
    send_beat(6'd9, 32'h500, 1'b1, 64'h55667788_99AABBCC, 8'h0F);
    drain("strb");

    // Reset with buffered beats drops them
    bus.tcdm_gnt_i = 2'b00;
    for (int k = 0; k < 3; k++)
      send_beat(6'd3, 32'h600 + 32'(8 * k), 1'b0, {32'h1600_0000 + 32'(k), 32'h0600_0000 + 32'(k)}, 8'hFF);
    rst_n = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    id_q.delete();
    @(negedge clk);
    check("mrst_tcdm_req", 64'(bus.tcdm_req_o), 64'h0);
    check("mrst_tcdm_add", bus.tcdm_add_o, 64'h0);
    check("mrst_tcdm_be", 64'(bus.tcdm_be_o), 64'h0);
    check("mrst_tcdm_wdata", bus.tcdm_wdata_o, 64'h0);
    check("mrst_tcdm_wen", 64'(bus.tcdm_wen_o), 64'h0);
    check("mrst_gnts", 64'({bus.trans_gnt_o, bus.data_gnt_o}), 64'h0);
    check("mrst_r_req", 64'({bus.trans_r_req_o, bus.trans_r_id_o}), 64'h0);
    bus.tcdm_gnt_i = 2'b11;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("mrst_after_no_req", 64'(bus.tcdm_req_o), 64'h0);
    check("mrst_after_no_resp", 64'(bus.trans_r_req_o), 64'h0);
    check("mrst_after_gnt", 64'({bus.trans_gnt_o, bus.data_gnt_o}), 64'h7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
